// File: rtl/cpu_pkg.sv
// Shared types and defaults for the multi-port CPU register file.
package cpu_pkg;

   // Stack-pointer operation requested alongside the ordinary write ports.
   typedef enum logic [1:0] {
      SP_HOLD = 2'b00,
      SP_LOAD = 2'b01,
      SP_INC  = 2'b10,
      SP_DEC  = 2'b11
   } sp_op_e;

   localparam logic [31:0] SP_RST_DEFAULT  = 32'h0000_0100;
   localparam int unsigned SP_STEP_DEFAULT = 4;

endpackage

// File: rtl/rf_next_mux.sv
// Next-state resolver for a single register: SP update > write port 1 > write port 0 > hold.
module rf_next_mux
   import cpu_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter bit          IS_SP   = 1'b0,
   parameter int unsigned SP_STEP = SP_STEP_DEFAULT
) (
   input  logic [DW-1:0] cur_i,
   input  sp_op_e        sp_op_i,
   input  logic [DW-1:0] sp_wd_i,
   input  logic          wr0_i,
   input  logic [DW-1:0] wd0_i,
   input  logic          wr1_i,
   input  logic [DW-1:0] wd1_i,
   output logic [DW-1:0] nxt_o
);

   localparam logic [DW-1:0] StepDw = DW'(SP_STEP);

   // Priority select; SP arithmetic wraps modulo 2^DW and uses the pre-edge value.
   always_comb begin
      nxt_o = cur_i;
      if (IS_SP && (sp_op_i != SP_HOLD)) begin
         unique case (sp_op_i)
            SP_LOAD: nxt_o = sp_wd_i;
            SP_INC:  nxt_o = cur_i + StepDw;
            SP_DEC:  nxt_o = cur_i - StepDw;
            default: nxt_o = cur_i;
         endcase
      end else if (wr1_i) begin
         nxt_o = wd1_i;
      end else if (wr0_i) begin
         nxt_o = wd0_i;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, built-in SP push/pop, two latched read
// ports plus a latched SP copy, with optional same-cycle write-to-read bypass.
module register_file_mp
   import cpu_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned NREG    = 8,
   parameter int unsigned SP_IDX  = 4,
   parameter logic [31:0] SP_RST  = SP_RST_DEFAULT,
   parameter int unsigned SP_STEP = SP_STEP_DEFAULT,
   parameter bit          BYPASS  = 1'b1,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               re,
   input  logic [AW-1:0]      ra1,
   input  logic [AW-1:0]      ra2,
   input  logic               we0,
   input  logic [AW-1:0]      wa0,
   input  logic [DW-1:0]      wd0,
   input  logic               we1,
   input  logic [AW-1:0]      wa1,
   input  logic [DW-1:0]      wd1,
   input  logic [1:0]         sp_op,
   input  logic [DW-1:0]      sp_wd,
   output logic [DW-1:0]      rd1,
   output logic [DW-1:0]      rd2,
   output logic [DW-1:0]      sp_q,
   output logic               rd_vld,
   output logic [NREG*DW-1:0] dbg_rf
);

   localparam logic [DW-1:0] SpRstDw = DW'(SP_RST);

   logic [DW-1:0] rf_q   [NREG];
   logic [DW-1:0] rf_d   [NREG];
   logic [DW-1:0] rd_src [NREG];

   logic [DW-1:0] rd1_q, rd1_d;
   logic [DW-1:0] rd2_q, rd2_d;
   logic [DW-1:0] sp_lat_q, sp_lat_d;
   logic          rd_vld_q;

   sp_op_e sp_op_s;
   assign sp_op_s = sp_op_e'(sp_op);

   // One resolver per register; the shared rf_d vector drives both storage and bypass.
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      rf_next_mux #(
         .DW      (DW),
         .IS_SP   (i == SP_IDX),
         .SP_STEP (SP_STEP)
      ) u_next (
         .cur_i   (rf_q[i]),
         .sp_op_i (sp_op_s),
         .sp_wd_i (sp_wd),
         .wr0_i   (we0 && (wa0 == AW'(i))),
         .wd0_i   (wd0),
         .wr1_i   (we1 && (wa1 == AW'(i))),
         .wd1_i   (wd1),
         .nxt_o   (rf_d[i])
      );

      assign rd_src[i]            = BYPASS ? rf_d[i] : rf_q[i];
      assign dbg_rf[i*DW +: DW]   = rf_q[i];
   end

   // Register storage; reset drops any write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= (i == SP_IDX) ? SpRstDw : '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   // Read latch next-state: capture on re, otherwise hold.
   always_comb begin
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;
      sp_lat_d = sp_lat_q;
      if (re) begin
         rd1_d    = rd_src[ra1];
         rd2_d    = rd_src[ra2];
         sp_lat_d = rd_src[SP_IDX];
      end
   end

   // Read latches and the valid strobe, which simply follows re by one cycle.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rd1_q    <= '0;
         rd2_q    <= '0;
         sp_lat_q <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         sp_lat_q <= sp_lat_d;
         rd_vld_q <= re;
      end
   end

   assign rd1    = rd1_q;
   assign rd2    = rd2_q;
   assign sp_q   = sp_lat_q;
   assign rd_vld = rd_vld_q;

endmodule
